// File: rtl/sad_block_mem.sv
// Dual-bank responder memory for the SAD datapath: pipelined A/B reads, shared-strobe
// writes, and a clear engine that zeroes both banks one word per cycle.
module sad_block_mem #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [AW-1:0] A_Addr,
    input  logic [AW-1:0] B_Addr,
    input  logic          RW,
    input  logic          En,
    input  logic [DW-1:0] A_WrData,
    input  logic [DW-1:0] B_WrData,
    input  logic          Init,
    output logic [DW-1:0] A_Data,
    output logic [DW-1:0] B_Data,
    output logic          Rd_Valid,
    output logic          Busy,
    output logic          Drop_Err
);
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          PS      = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0] LAST_W  = DEPTH_W - {{AW{1'b0}}, 1'b1};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_nx;
    logic [AW:0]   cnt;
    logic          clr_we;
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    logic          a_ok, b_ok, acc_ok, rd_issue, wr_issue;
    logic [DW-1:0] rd_a, rd_b;
    logic          fin_vld;
    logic [DW-1:0] fin_a, fin_b;

    // Init outranks an access presented in the same cycle.
    assign acc_ok   = En && (state == IDLE) && !Init;
    assign rd_issue = acc_ok && !RW;
    assign wr_issue = acc_ok && RW;
    assign a_ok     = {1'b0, A_Addr} < DEPTH_W;
    assign b_ok     = {1'b0, B_Addr} < DEPTH_W;
    assign rd_a     = a_ok ? mem_a[A_Addr[IW-1:0]] : '0;
    assign rd_b     = b_ok ? mem_b[B_Addr[IW-1:0]] : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && Init) cnt <= '0;
            else if (state == CLEAR)   cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Init) state_nx = CLEAR;
            CLEAR:   if (cnt == LAST_W) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy   = (state == CLEAR);
        clr_we = (state == CLEAR) && !Rst;
    end

    // Reset leaves array contents alone, including the word the clear was about to hit.
    always_ff @(posedge Clk) begin
        if (clr_we) begin
            mem_a[cnt[IW-1:0]] <= '0;
            mem_b[cnt[IW-1:0]] <= '0;
        end else if (wr_issue && !Rst) begin
            if (a_ok) mem_a[A_Addr[IW-1:0]] <= A_WrData;
            if (b_ok) mem_b[B_Addr[IW-1:0]] <= B_WrData;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            assign fin_vld = rd_issue;
            assign fin_a   = rd_a;
            assign fin_b   = rd_b;
        end else begin : g_pipe
            logic [PS-1:0]         vld_pipe;
            logic [PS-1:0][DW-1:0] pa, pb;

            always_ff @(posedge Clk) begin
                if (Rst) vld_pipe <= '0;
                else begin
                    vld_pipe[0] <= rd_issue;
                    for (int i = 1; i < PS; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
                pa[0] <= rd_a;
                pb[0] <= rd_b;
                for (int i = 1; i < PS; i++) begin
                    pa[i] <= pa[i-1];
                    pb[i] <= pb[i-1];
                end
            end

            assign fin_vld = vld_pipe[PS-1];
            assign fin_a   = pa[PS-1];
            assign fin_b   = pb[PS-1];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            A_Data   <= '0;
            B_Data   <= '0;
            Rd_Valid <= 1'b0;
        end else begin
            Rd_Valid <= fin_vld;
            if (fin_vld) begin
                A_Data <= fin_a;
                B_Data <= fin_b;
            end
        end
    end

    // A dropped access sets the flag even when the same-cycle Init would clear it.
    always_ff @(posedge Clk) begin
        if (Rst)                          Drop_Err <= 1'b0;
        else if (En && (Busy || Init))    Drop_Err <= 1'b1;
        else if (Init && state == IDLE)   Drop_Err <= 1'b0;
    end
endmodule

// File: tb/tb_sad_block_mem.sv
// Scoreboard bench: two instances (RD_LAT=1 and RD_LAT=3) share stimulus; reads push
// expected data and due cycle, a negedge monitor pops on Rd_Valid.
module tb_sad_block_mem;
    localparam int DW = 8, AW = 8, DEPTH = 256;

    logic          Clk = 1'b0;
    logic          Rst, RW, En, Init;
    logic [AW-1:0] A_Addr, B_Addr;
    logic [DW-1:0] A_WrData, B_WrData;
    logic [DW-1:0] a1, b1, a3, b3;
    logic          v1, v3, busy1, busy3, de1, de3;

    sad_block_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(1)) u_l1 (
        .Clk(Clk), .Rst(Rst), .A_Addr(A_Addr), .B_Addr(B_Addr), .RW(RW), .En(En),
        .A_WrData(A_WrData), .B_WrData(B_WrData), .Init(Init),
        .A_Data(a1), .B_Data(b1), .Rd_Valid(v1), .Busy(busy1), .Drop_Err(de1));

    sad_block_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(3)) u_l3 (
        .Clk(Clk), .Rst(Rst), .A_Addr(A_Addr), .B_Addr(B_Addr), .RW(RW), .En(En),
        .A_WrData(A_WrData), .B_WrData(B_WrData), .Init(Init),
        .A_Data(a3), .B_Data(b3), .Rd_Valid(v3), .Busy(busy3), .Drop_Err(de3));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            due;
    } exp_t;

    exp_t          q [2][$];
    logic [1:0]    vv;
    logic [DW-1:0] da [2];
    logic [DW-1:0] db [2];
    int            checks = 0, errors = 0;
    int            sum = 0;
    bit            sum_on = 0;

    assign vv    = {v3, v1};
    assign da[0] = a1;
    assign db[0] = b1;
    assign da[1] = a3;
    assign db[1] = b3;

    always @(negedge Clk) begin
        for (int p = 0; p < 2; p++) begin
            if (vv[p]) begin
                checks++;
                if (q[p].size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected lat%0d: Rd_Valid at cycle %0d with nothing pending", p*2+1, cyc);
                end else begin
                    exp_t e;
                    e = q[p].pop_front();
                    if (e.a !== da[p] || e.b !== db[p] || e.due != cyc) begin
                        errors++;
                        $display("FAIL rd_data lat%0d: got A=%0d B=%0d at cycle %0d, expected A=%0d B=%0d at cycle %0d",
                                 p*2+1, da[p], db[p], cyc, e.a, e.b, e.due);
                    end
                end
                if (p == 0 && sum_on) sum += (da[0] > db[0]) ? int'(da[0] - db[0]) : int'(db[0] - da[0]);
            end else if (q[p].size() != 0 && q[p][0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_missing lat%0d: no Rd_Valid by cycle %0d, expected at %0d", p*2+1, cyc, q[p][0].due);
                void'(q[p].pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic rd(input int adr_a, input int adr_b, input int ea, input int eb);
        exp_t e;
        e.a = ea[DW-1:0]; e.b = eb[DW-1:0];
        e.due = cyc + 1; q[0].push_back(e);
        e.due = cyc + 3; q[1].push_back(e);
        A_Addr = adr_a[AW-1:0]; B_Addr = adr_b[AW-1:0]; RW = 1'b0; En = 1'b1;
        tick();
        En = 1'b0;
    endtask

    task automatic wr(input int adr, input int wa, input int wb);
        A_Addr = adr[AW-1:0]; B_Addr = adr[AW-1:0];
        A_WrData = wa[DW-1:0]; B_WrData = wb[DW-1:0]; RW = 1'b1; En = 1'b1;
        tick();
        En = 1'b0; RW = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (q[0].size() != 0 || q[1].size() != 0); k++) tick();
        tick();
        chk("drain_pending", q[0].size() + q[1].size(), 0);
    endtask

    task automatic clear_run(input int en_at, input int init_at, output int n);
        n = 0;
        while (busy1 && n < 400) begin
            n++;
            En = (n == en_at); RW = 1'b0; A_Addr = 8'd7; B_Addr = 8'd7;
            Init = (n == init_at);
            tick();
        end
        En = 1'b0; Init = 1'b0;
    endtask

    task automatic pulse_init();
        Init = 1'b1;
        tick();
        Init = 1'b0;
    endtask

    initial begin
        int n;
        Rst = 1'b1; RW = 1'b0; En = 1'b0; Init = 1'b0;
        A_Addr = '0; B_Addr = '0; A_WrData = '0; B_WrData = '0;
        tick(); tick();
        chk("rst_a1", a1, 0);   chk("rst_b1", b1, 0);   chk("rst_v1", v1, 0);
        chk("rst_busy", busy1, 0); chk("rst_derr", de1, 0);
        chk("rst_a3", a3, 0);   chk("rst_v3", v3, 0);
        Rst = 1'b0;

        for (int i = 0; i < 256; i++) wr(i, i, 255 - i);
        rd(10, 10, 10, 245);
        drain();

        rd(0, 0, 0, 255); rd(1, 1, 1, 254); rd(2, 2, 2, 253);
        drain();
        chk("hold_a1", a1, 2); chk("hold_b3", b3, 253);

        rd(255, 255, 255, 0);
        rd(5, 5, 5, 250);
        wr(5, 77, 77);
        rd(5, 5, 77, 77);
        drain();

        // First clear: read dropped at busy cycle 5, Init ignored at busy cycle 10.
        pulse_init();
        chk("busy_start", busy1, 1);
        clear_run(5, 10, n);
        chk("busy_len", n, 256);
        chk("busy3_done", busy3, 0);
        chk("derr_set", de1, 1);
        rd(0, 255, 0, 0);
        rd(255, 0, 0, 0);
        drain();
        chk("derr_sticky", de1, 1);
        chk("derr_sticky3", de3, 1);

        // Init and read together in IDLE: Init wins, access dropped and flagged.
        A_Addr = 8'd3; B_Addr = 8'd3; RW = 1'b0; En = 1'b1; Init = 1'b1;
        tick();
        En = 1'b0; Init = 1'b0;
        chk("init_en_busy", busy1, 1);
        chk("init_en_derr", de1, 1);
        clear_run(0, 0, n);
        chk("busy_len2", n, 256);
        pulse_init();
        chk("init_clr_derr", de1, 0);
        clear_run(0, 0, n);

        // Reset at busy cycle 100 after refilling.
        for (int i = 0; i < 256; i++) wr(i, i, 255 - i);
        pulse_init();
        repeat (100) tick();
        chk("mid_busy", busy1, 1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rst_mid_busy", busy1, 0);
        chk("rst_mid_derr", de1, 0);
        rd(99, 99, 0, 0);
        rd(200, 200, 200, 55);
        drain();

        // SAD-style pass: |A-B| summed over all addresses with B cleared to 0.
        for (int i = 0; i < 256; i++) wr(i, i, 0);
        sum = 0;
        sum_on = 1;
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            e.a = i[DW-1:0]; e.b = '0;
            e.due = cyc + 1; q[0].push_back(e);
            e.due = cyc + 3; q[1].push_back(e);
            A_Addr = i[AW-1:0]; B_Addr = i[AW-1:0]; RW = 1'b0; En = 1'b1;
            tick();
        end
        En = 1'b0;
        drain();
        sum_on = 0;
        chk("sad_sum", sum, 32640);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sad_block_mem.md
Name: sad_block_mem

Overview:
Dual-bank block memory acting as the responder for the SAD datapath's A/B memory interface. It accepts the SAD initiator's address, RW and En signals and returns the A/B read data with a fixed, parameterised latency. It also accepts writes so a testbench or loader can fill the two frames, and it includes a clear engine that zeroes both banks on request. It is instantiated beside the SAD block in the top level and in testbenches.

Parameters:
DW, 8, data word width; default equals project `D_WIDTH.
AW, 8, address width; default equals project `A_WIDTH.
DEPTH, 256, words per bank; must be ≤ 2**AW.
RD_LAT, 1, read latency in clock edges; legal values 1..3.

Ports:
Clk  input  1  clock, all logic on rising edge.
Rst  input  1  synchronous, active-high reset.
A_Addr  input  AW  bank A address.
B_Addr  input  AW  bank B address.
RW  input  1  0 = read, 1 = write; shared by both banks.
En  input  1  access strobe; one access per cycle while high.
A_WrData  input  DW  bank A write data.
B_WrData  input  DW  bank B write data.
Init  input  1  one-cycle pulse that starts clearing both banks.
A_Data  output  DW  bank A read data.
B_Data  output  DW  bank B read data.
Rd_Valid  output  1  one-cycle pulse when A_Data/B_Data are updated.
Busy  output  1  high while clearing.
Drop_Err  output  1  sticky; an access arrived while Busy.

Behaviour:
- Reset (Rst=1 at an edge):
  - A_Data, B_Data, Rd_Valid, Busy and Drop_Err all go to 0.
  - The read pipeline is flushed.
  - The FSM goes to IDLE.
  - Array contents are not modified.
- Read:
  - Issued at an edge where En=1, RW=0 and the FSM is in IDLE.
  - Both banks are read at their own addresses. The array is sampled at issue.
  - A_Data and B_Data take the new values at the RD_LAT-th edge after issue. Rd_Valid is 1 for exactly that cycle.
  - Outputs hold their last read value until the next read completes; they are not zeroed between reads.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- Timing requirement with SAD at RD_LAT=1:
  - SAD asserts En/Addr in its address state.
  - The memory issues the read at the next edge.
  - Data is valid during SAD's absdiff state, so SAD's sum register captures the correct value.
- Write:
  - Issued at an edge where En=1, RW=1 and the FSM is in IDLE.
  - A_WrData is written to bank A at A_Addr, and B_WrData to bank B at B_Addr, at that edge.
  - No Rd_Valid is generated. Read outputs are unchanged.
- Read in flight vs. later write to the same address: the read returns the old data, because the array is sampled at issue.
- Addresses ≥ DEPTH:
  - Reads return 0.
  - Writes are ignored.
  - Drop_Err is not set.
- Clear FSM: IDLE → CLEAR → IDLE.
  - IDLE: if Init=1, go to CLEAR with counter=0, Busy=1, and Drop_Err cleared to 0.
  - CLEAR: each cycle write 0 to both banks at the counter address, then increment.
  - After writing DEPTH-1, the next state is IDLE and Busy=0.
  - Total Busy time is exactly DEPTH cycles.
  - In-flight reads issued before Init still complete normally.
- En=1 while Busy:
  - The access is dropped.
  - Drop_Err is set at that edge and stays set until Rst or the next Init.
- Init while Busy is ignored; the counter does not restart.
- Init and En in the same IDLE cycle: Init wins, the access is dropped, and Drop_Err is set.
- Rst mid-CLEAR:
  - Busy goes to 0 immediately.
  - The remaining words keep their prior contents.
- Widths:
  - The counter is AW+1 bits so DEPTH=2**AW terminates.
  - Read data is zero-extended DW; no arithmetic on data.

Test Plan:
- Rst, then write A[i]=i and B[i]=255-i for i=0..255, then read addr 10 → one cycle after issue A_Data=10, B_Data=245, Rd_Valid=1 for 1 cycle.
- Back-to-back reads of addresses 0,1,2 with RD_LAT=3 → Rd_Valid pulses on 3 consecutive cycles starting 3 edges after the first issue, with A_Data=0,1,2.
- Pulse Init → Busy high exactly 256 cycles. Then read addr 0 and addr 255 → A_Data=0 and B_Data=0.
- En read at cycle 5 of clearing → no Rd_Valid, Drop_Err=1 and stays 1; a later Init clears it to 0.
- Rst at cycle 100 of clearing after the fill pattern → Busy=0 next cycle; addr 99 reads 0/0, addr 200 reads 200/55.
- Connect to SAD with A[i]=i and B[i]=0 → SAD result 32640 (sum 0..255) with Done asserted.
